sprite_render: RTL and testbench
================================

SPRITE_RENDER -- requirements
Module: sprite_render

Interface
REQ-001 The parameter SCALE_SHIFT, default 2, SHALL set the sprite magnification to 2^SCALE_SHIFT, so the displayed size is (32<<SCALE_SHIFT) pixels square.
REQ-002 The parameter ORIGIN_X, default 256, SHALL set the sprite top-left hpos at reset.
REQ-003 The parameter ORIGIN_Y, default 176, SHALL set the sprite top-left vpos (fixed).
REQ-004 The parameter FRAME_DIV, default 8, SHALL set the number of video frames per animation step; legal range 1..255.
REQ-005 The parameter BG_COLOR, default 6'b000001, SHALL set the RRGGBB colour for transparent and outside-box pixels.
REQ-006 The port list SHALL be, in order:
- clk  in  1  system clock, the single clock.
- rst  in  1  reset, asynchronous, active-high.
- hpos  in  10  current pixel column.
- vpos  in  10  current pixel row.
- display_on  in  1  visible-area flag for hpos/vpos.
- frame_start  in  1  single-cycle pulse at the start of each video frame.
- lut_x  out  5  sprite column to the bitmap LUT.
- lut_y  out  5  sprite row to the bitmap LUT.
- frame_sel  out  2  animation frame index, used to select the bitmap.
- lut_pixel  in  3  palette index returned combinationally by the LUT.
- rgb  out  6  RRGGBB colour.
- rgb_valid  out  1  rgb corresponds to a visible pixel.

Function
REQ-007 Stage 1 SHALL register lut_x = (hpos-ox)>>SCALE_SHIFT[4:0], lut_y = (vpos-ORIGIN_Y)>>SCALE_SHIFT[4:0], the in_box flag, and display_on.
REQ-008 The in_box flag SHALL be set iff ox <= hpos < ox+(32<<SCALE_SHIFT) and ORIGIN_Y <= vpos < ORIGIN_Y+(32<<SCALE_SHIFT); the lower bounds are inclusive and the upper bounds are exclusive.
REQ-009 When in_box is clear, lut_x and lut_y SHALL be 0.
REQ-010 Stage 2 SHALL register rgb from the stage-1 flags and lut_pixel, giving a total latency of exactly 2 clk cycles from hpos/vpos to rgb/rgb_valid.
REQ-011 The palette SHALL map indices 1..7 to 111111, 000000, 111000, 101010, 110000, 001100, 000011 respectively; index 0 SHALL be transparent and SHALL output BG_COLOR.
REQ-012 rgb SHALL be BG_COLOR when display_on was set but in_box was clear, and SHALL be 000000 with rgb_valid=0 when display_on was clear.
REQ-013 The divider SHALL increment on each frame_start; when it reaches FRAME_DIV-1 and frame_start fires, it SHALL wrap to 0 and frame_sel SHALL increment modulo 4 (3 wraps to 0).
REQ-014 frame_sel and ox SHALL change only on a frame_start cycle; a pixel sampled in the same cycle as frame_start SHALL use the pre-update values.
REQ-015 With display_on=1 and frame_start=1 in the same cycle, the block SHALL process both with no lost pixel.

Reset
REQ-016 While rst=1, all outputs SHALL be 0 (lut_x, lut_y, frame_sel, rgb, rgb_valid), the divider SHALL be 0, ox SHALL be ORIGIN_X, and the bounce direction SHALL be right.
REQ-017 Reset asserted mid-line SHALL flush both pipeline stages; the first valid rgb SHALL appear 2 cycles after the first post-reset visible pixel.

Configuration
REQ-018 With the macro SPRITE_BOUNCE_EN defined, ox SHALL move by 1 per frame_start in the current direction.
- At ox = 640-(32<<SCALE_SHIFT) (512 by default) the direction SHALL become left, and at ox = 0 it SHALL become right.
- The turnaround frame SHALL not move; ox holds for that one frame.
REQ-019 Without SPRITE_BOUNCE_EN, ox SHALL be the constant ORIGIN_X, and no direction or position register SHALL exist.

Verification
REQ-020 Pixel at hpos=256, vpos=176, display_on=1, with lut_pixel=1 returned -> lut_x=0, lut_y=0 after 1 cycle; rgb=111111, rgb_valid=1 after 2 cycles.
REQ-021 Box edges: hpos=383 -> lut_x=31; hpos=384 -> rgb=BG_COLOR; hpos=255 -> rgb=000001.
REQ-022 lut_pixel=0 inside the box -> rgb=000001; display_on=0 -> rgb=000000 with rgb_valid=0.
REQ-023 32 frame_start pulses -> frame_sel goes 0→1 after the 8th pulse and wraps 3→0 after the 32nd.
REQ-024 rst pulsed while a pipeline pixel is valid -> rgb_valid=0 immediately, frame_sel=0, and ox=256.
REQ-025 With SPRITE_BOUNCE_EN defined and 256 frames from reset -> ox=512; the next frame holds at 512, and the frame after that gives ox=511.

Source files
------------

// File: rtl/sprite_render.sv
// Sprite renderer: maps a raster position to a magnified 32x32 bitmap
// and colours it through a fixed palette; optional bounce via SPRITE_BOUNCE_EN.
module sprite_render #(
    parameter int          SCALE_SHIFT = 2,
    parameter int          ORIGIN_X    = 256,
    parameter int          ORIGIN_Y    = 176,
    parameter int          FRAME_DIV   = 8,
    parameter logic [5:0]  BG_COLOR    = 6'b000001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       frame_start,
    output logic [4:0] lut_x,
    output logic [4:0] lut_y,
    output logic [1:0] frame_sel,
    input  logic [2:0] lut_pixel,
    output logic [5:0] rgb,
    output logic       rgb_valid
);

    localparam int         SIZE     = 32 << SCALE_SHIFT;
    localparam logic [10:0] SIZE11  = 11'(SIZE);
    localparam logic [10:0] OY11    = 11'(ORIGIN_Y);
    localparam logic [9:0]  OY10    = 10'(ORIGIN_Y);
    localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

    logic [9:0] ox;
    logic [7:0] div;

    logic       x_hit;
    logic       y_hit;
    logic       in_box;
    logic [4:0] lx_next;
    logic [4:0] ly_next;

    logic       in_box_q;
    logic       disp_q;
    logic [5:0] pal;

`ifdef SPRITE_BOUNCE_EN
    localparam logic [9:0] OX_MAX = 10'(640 - SIZE);

    logic dir_left;

    // Horizontal bounce: step one pixel per frame, holding for the turnaround frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ox       <= 10'(ORIGIN_X);
            dir_left <= 1'b0;
        end else if (frame_start) begin
            if (!dir_left) begin
                if (ox == OX_MAX)
                    dir_left <= 1'b1;
                else
                    ox <= ox + 10'd1;
            end else begin
                if (ox == 10'd0)
                    dir_left <= 1'b0;
                else
                    ox <= ox - 10'd1;
            end
        end
    end
`else
    assign ox = 10'(ORIGIN_X);
`endif

    // Box test uses 11-bit sums so the exclusive upper edge cannot wrap
    always_comb begin
        x_hit = ({1'b0, hpos} >= {1'b0, ox}) &&
                ({1'b0, hpos} < ({1'b0, ox} + SIZE11));
        y_hit = ({1'b0, vpos} >= OY11) &&
                ({1'b0, vpos} < (OY11 + SIZE11));
        in_box = x_hit && y_hit;
        lx_next = 5'd0;
        ly_next = 5'd0;
        if (in_box) begin
            lx_next = 5'((hpos - ox) >> SCALE_SHIFT);
            ly_next = 5'((vpos - OY10) >> SCALE_SHIFT);
        end
    end

    // Stage 1: bitmap coordinates and pixel qualifiers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_x    <= 5'd0;
            lut_y    <= 5'd0;
            in_box_q <= 1'b0;
            disp_q   <= 1'b0;
        end else begin
            lut_x    <= lx_next;
            lut_y    <= ly_next;
            in_box_q <= in_box;
            disp_q   <= display_on;
        end
    end

    // Palette lookup; index 0 is transparent
    always_comb begin
        pal = BG_COLOR;
        unique case (lut_pixel)
            3'd0: pal = BG_COLOR;
            3'd1: pal = 6'b111111;
            3'd2: pal = 6'b000000;
            3'd3: pal = 6'b111000;
            3'd4: pal = 6'b101010;
            3'd5: pal = 6'b110000;
            3'd6: pal = 6'b001100;
            3'd7: pal = 6'b000011;
        endcase
    end

    // Stage 2: final colour, blanked outside the visible area
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= 6'd0;
            rgb_valid <= 1'b0;
        end else if (!disp_q) begin
            rgb       <= 6'd0;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= in_box_q ? pal : BG_COLOR;
            rgb_valid <= 1'b1;
        end
    end

    // Animation: advance frame_sel once every FRAME_DIV frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= 8'd0;
            frame_sel <= 2'd0;
        end else if (frame_start) begin
            if (div == DIV_LAST) begin
                div       <= 8'd0;
                frame_sel <= frame_sel + 2'd1;
            end else begin
                div <= div + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render with immediate-assertion checks.
module tb_sprite_render;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       frame_start = 1'b0;
    logic [4:0] lut_x;
    logic [4:0] lut_y;
    logic [1:0] frame_sel;
    logic [2:0] lut_pixel = '0;
    logic [5:0] rgb;
    logic       rgb_valid;

    int checks = 0;
    int errors = 0;

    sprite_render dut (
        .clk(clk),
        .rst(rst),
        .hpos(hpos),
        .vpos(vpos),
        .display_on(display_on),
        .frame_start(frame_start),
        .lut_x(lut_x),
        .lut_y(lut_y),
        .frame_sel(frame_sel),
        .lut_pixel(lut_pixel),
        .rgb(rgb),
        .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one pixel, check stage-1 outputs, then the colour a cycle later
    task automatic pix(input string tag, input int h, input int v,
                       input bit d, input int p, input int elx,
                       input int ely, input int ergb, input bit ev);
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = d;
        lut_pixel = 3'(p);
        tick();
        chk({tag, ".lut_x"}, 32'(lut_x), 32'(elx));
        chk({tag, ".lut_y"}, 32'(lut_y), 32'(ely));
        chk({tag, ".early_valid"}, 32'(rgb_valid), 32'd0);
        display_on = 1'b0;
        hpos = '0;
        vpos = '0;
        tick();
        chk({tag, ".rgb"}, 32'(rgb), 32'(ergb));
        chk({tag, ".valid"}, 32'(rgb_valid), 32'(ev));
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst.lut_x", 32'(lut_x), 32'd0);
        chk("rst.lut_y", 32'(lut_y), 32'd0);
        chk("rst.frame_sel", 32'(frame_sel), 32'd0);
        chk("rst.rgb", 32'(rgb), 32'd0);
        chk("rst.valid", 32'(rgb_valid), 32'd0);
        chk("rst.div", 32'(dut.div), 32'd0);
        chk("rst.ox", 32'(dut.ox), 32'd256);
        rst = 1'b0;
        tick();

        // Pixel mapping, box edges and palette
        pix("origin", 256, 176, 1, 1, 0, 0, 6'b111111, 1);
        pix("x_last", 383, 176, 1, 3, 31, 0, 6'b111000, 1);
        pix("x_past", 384, 176, 1, 1, 0, 0, 6'b000001, 1);
        pix("x_before", 255, 176, 1, 1, 0, 0, 6'b000001, 1);
        pix("transp", 300, 200, 1, 0, 11, 6, 6'b000001, 1);
        pix("blank", 300, 200, 0, 2, 11, 6, 6'b000000, 0);
        pix("y_last", 256, 303, 1, 7, 0, 31, 6'b000011, 1);
        pix("y_past", 256, 304, 1, 7, 0, 0, 6'b000001, 1);
        pix("y_before", 256, 175, 1, 7, 0, 0, 6'b000001, 1);
        pix("pal2", 260, 180, 1, 2, 1, 1, 6'b000000, 1);
        pix("pal4", 264, 184, 1, 4, 2, 2, 6'b101010, 1);
        pix("pal5", 268, 188, 1, 5, 3, 3, 6'b110000, 1);
        pix("pal6", 272, 192, 1, 6, 4, 4, 6'b001100, 1);
        pix("corner", 383, 303, 1, 1, 31, 31, 6'b111111, 1);

        // Animation divider; pulse 8 also carries a visible pixel
        for (int n = 1; n <= 32; n++) begin
            if (n == 8) begin
                hpos = 10'd256;
                vpos = 10'd176;
                display_on = 1'b1;
                lut_pixel = 3'd1;
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
                display_on = 1'b0;
                chk("fs_pix.lut_x", 32'(lut_x), 32'd0);
                chk("fs_pix.frame_sel", 32'(frame_sel), 32'd1);
                tick();
                chk("fs_pix.rgb", 32'(rgb), 32'(6'b111111));
                chk("fs_pix.valid", 32'(rgb_valid), 32'd1);
            end else begin
                pulse();
                chk($sformatf("frame_sel.%0d", n), 32'(frame_sel),
                    32'((n / 8) % 4));
            end
        end

        // Reset while a pixel sits in the pipeline
        for (int n = 0; n < 8; n++) pulse();
        chk("pre_rst.frame_sel", 32'(frame_sel), 32'd1);
        hpos = 10'd300;
        vpos = 10'd200;
        display_on = 1'b1;
        lut_pixel = 3'd1;
        tick();
        tick();
        chk("pre_rst.valid", 32'(rgb_valid), 32'd1);
        chk("pre_rst.lut_x", 32'(lut_x), 32'd11);
        rst = 1'b1;
        #1;
        chk("mid_rst.valid", 32'(rgb_valid), 32'd0);
        chk("mid_rst.rgb", 32'(rgb), 32'd0);
        chk("mid_rst.lut_x", 32'(lut_x), 32'd0);
        chk("mid_rst.frame_sel", 32'(frame_sel), 32'd0);
        chk("mid_rst.ox", 32'(dut.ox), 32'd256);
        chk("mid_rst.div", 32'(dut.div), 32'd0);
        tick();
        rst = 1'b0;
        hpos = 10'd256;
        vpos = 10'd176;
        tick();
        chk("post_rst.valid1", 32'(rgb_valid), 32'd0);
        tick();
        chk("post_rst.valid2", 32'(rgb_valid), 32'd1);
        chk("post_rst.rgb", 32'(rgb), 32'(6'b111111));
        display_on = 1'b0;

`ifdef SPRITE_BOUNCE_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 256; n++) pulse();
        chk("bounce.256", 32'(dut.ox), 32'd512);
        pulse();
        chk("bounce.hold", 32'(dut.ox), 32'd512);
        pulse();
        chk("bounce.back", 32'(dut.ox), 32'd511);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
